// File: rtl/fpaddsub_norm_seq_32.sv
// Iterative normaliser for the FP add/sub datapath: a one-bit right shift on carry-out,
// or coarse/fine left shifts until the hidden one reaches bit 25. Held in DONE until accepted.
module fpaddsub_norm_seq_32 #(
  parameter int STEP   = 4,
  parameter int SIDE_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [26:0]       Sum,
  input  logic              SumS,
  input  logic [7:0]        CExp,
  input  logic [SIDE_W-1:0] SideIn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [22:0]       NormM,
  output logic [8:0]        NormE,
  output logic              G,
  output logic              R,
  output logic              S,
  output logic              ZeroSum,
  output logic              NegE,
  output logic [SIDE_W-1:0] SideOut
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t             state, state_nx;
  logic [26:0]        w, w_nx;
  logic signed [9:0]  e, e_nx, e_inc;
  logic               st, st_nx;
  logic               zs, zs_nx;
  logic               nege, nege_nx;
  logic [SIDE_W-1:0]  side_q;

  assign e_inc = e + 10'sd1;

  always_comb begin
    state_nx = state;
    w_nx     = w;
    e_nx     = e;
    st_nx    = st;
    zs_nx    = zs;
    nege_nx  = nege;
    case (state)
      IDLE: begin
        if (in_valid) begin
          w_nx     = Sum;
          e_nx     = signed'({2'b00, CExp});
          st_nx    = SumS;
          zs_nx    = 1'b0;
          nege_nx  = 1'b0;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (w == 27'd0 && !st) begin
          zs_nx    = 1'b1;
          nege_nx  = 1'b0;
          e_nx     = '0;
          state_nx = DONE;
        end else if (w == 27'd0) begin
          // only sticky survived alignment: total underflow
          zs_nx    = 1'b0;
          nege_nx  = 1'b1;
          e_nx     = '0;
          state_nx = DONE;
        end else if (w[26]) begin
          w_nx     = w >> 1;
          st_nx    = st | w[0];
          e_nx     = e_inc;
          nege_nx  = e_inc[9];
          state_nx = DONE;
        end else if (w[25]) begin
          nege_nx  = e[9];
          state_nx = DONE;
        end else if (w[25 -: STEP] == '0) begin
          w_nx = w << STEP;
          e_nx = e - 10'(STEP);
        end else begin
          w_nx = w << 1;
          e_nx = e - 10'sd1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      w      <= '0;
      e      <= '0;
      st     <= 1'b0;
      zs     <= 1'b0;
      nege   <= 1'b0;
      side_q <= '0;
    end else begin
      state <= state_nx;
      w     <= w_nx;
      e     <= e_nx;
      st    <= st_nx;
      zs    <= zs_nx;
      nege  <= nege_nx;
      if (state == IDLE && in_valid) side_q <= SideIn;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign NormM     = zs ? 23'd0 : w[24:2];
  assign G         = zs ? 1'b0 : w[1];
  assign R         = zs ? 1'b0 : w[0];
  assign S         = zs ? 1'b0 : st;
  assign NormE     = e[8:0];
  assign ZeroSum   = zs;
  assign NegE      = nege;
  assign SideOut   = side_q;

endmodule

// File: doc/fpaddsub_norm_seq_32.md
Name: fpaddsub_norm_seq_32

Overview:
- Multi-cycle normalisation stage of the single-precision FP add/sub datapath.
- Sits directly upstream of the rounding/packing stage. Takes the raw aligned mantissa sum plus the provisional exponent, and produces what that stage consumes: NormM, NormE, G, R, S, ZeroSum, NegE.
- Normalises iteratively: a 1-bit right shift on carry-out, or coarse/fine left shifts for leading zeros.
- Uses a valid/ready handshake on both sides and carries sign/control sideband unchanged.

Parameters:
- STEP, 4, coarse left-shift distance per cycle. Legal range 1..8.
- SIDE_W, 9, sideband width: {Sa, Sb, Ctrl, MaxAB, InputExc[4:0]}.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept; high only in IDLE.
- Sum  in  27  raw sum: [26] carry-out, [25] hidden-one position, [24:2] fraction, [1] guard, [0] round.
- SumS  in  1  sticky from alignment.
- CExp  in  8  provisional (larger operand) exponent.
- SideIn  in  SIDE_W  sideband, captured on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- NormM  out  23  normalised fraction.
- NormE  out  9  normalised exponent; bit 8 set means overflow.
- G  out  1  guard bit.
- R  out  1  round bit.
- S  out  1  sticky bit.
- ZeroSum  out  1  exact zero result.
- NegE  out  1  exponent went negative.
- SideOut  out  SIDE_W  captured sideband.

Behaviour:
- Internal state: W[26:0], E signed 10-bit, St, FSM {IDLE, NORM, DONE}.
- Reset (async): FSM=IDLE, W=0, E=0, St=0, ZeroSum=0, NegE=0, SideOut=0, out_valid=0. Therefore all outputs are 0 and in_ready=1.
- Accept: IDLE & in_valid. On the edge:
  - W<=Sum, E<=zero-extended CExp, St<=SumS, SideOut<=SideIn.
  - Go to NORM.
- NORM: exactly one action per cycle, in this priority order:
  1. W==0 & St==0: ZeroSum<=1, E<=0. Go to DONE.
  2. W==0 & St==1: ZeroSum<=0, NegE<=1, E<=0. Go to DONE (total underflow).
  3. W[26]: W<=W>>1, St<=St|W[0], E<=E+1. Go to DONE.
  4. W[25]: go to DONE with no change.
  5. W[25:26-STEP]==0: W<=W<<STEP, E<=E-STEP. Stay in NORM.
  6. Otherwise: W<=W<<1, E<=E-1. Stay in NORM.
  - Left shifts fill with 0. St is unchanged by left shifts.
- On entering DONE (all paths except the zero/underflow overrides above): NegE<=E_next[9].
- Output mapping:
  - NormM=W[24:2], G=W[1], R=W[0], S=St.
  - NormE=E[8:0]. When ZeroSum=1, NormM, G, R and S are all 0.
  - E=256 after the carry shift gives NormE[8]=1, which the rounding stage treats as overflow.
- DONE: out_valid=1; all outputs held stable. On out_valid & out_ready, go to IDLE.
  - The next accept is possible the cycle after the handshake (no same-cycle turnaround).
- Latency, accept edge to first cycle of out_valid: 2 + number of NORM shift cycles.
  - Carry, already-normalised or zero input: 2.
  - Worst case (lead one at bit 0, STEP=4): 2 + 6 coarse + 1 fine = 9.
- in_ready=0 in NORM and DONE. in_valid asserted then is ignored and not queued.
- Reset mid-NORM or mid-DONE aborts the operation; no out_valid is produced for it.
- E never wraps within one operation: minimum is CExp-25 ≥ -25, fits signed 10-bit.

Test Plan:
- Reset release → in_ready=1, out_valid=0, every output 0.
- Sum=27'h2000000, SumS=0, CExp=127, out_ready=1 → out_valid at accept+2; NormE=127, NormM=0, G=R=S=0, NegE=0, ZeroSum=0.
- Sum=27'h4000001, CExp=127 → carry path, latency 2; NormE=128, NormM=0, G=0, R=0, S=1.
- Sum=27'h0020000, CExp=20, STEP=4 → two coarse shifts, latency 4; NormE=12, NormM=0.
- Sum=27'h0000004, CExp=3 → 5 coarse + 3 fine shifts, latency 10; NegE=1, NormE=9'h1EC.
- Sum=0, SumS=0, SideIn=9'h1A5, out_ready low 5 cycles → ZeroSum=1, NormE=0; outputs and SideOut=9'h1A5 stable while stalled; in_ready stays 0.
- Assert rst during NORM of the previous case → immediate IDLE, no out_valid; the next accepted beat completes normally.
